// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard controller
// Contents:
//   ctrl_state_e        : MDU timer state {RUN, BUSY}
//   TUSE_NONE           : Tuse encoding for an operand that is not read
//   MULT_CYCLES_DEFAULT : default busy length after a mult/multu start
//   DIV_CYCLES_DEFAULT  : default busy length after a div/divu start
//   MD_CNT_W            : width of the MDU busy counter
package pipe_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      BUSY = 1'b1
   } ctrl_state_e;

   localparam logic [1:0] TUSE_NONE           = 2'd3;
   localparam int         MULT_CYCLES_DEFAULT = 5;
   localparam int         DIV_CYCLES_DEFAULT  = 10;
   localparam int         MD_CNT_W            = 4;

endpackage

// File: rtl/md_busy_timer.sv
// rtl/md_busy_timer.sv - multiply/divide busy timer (RUN/BUSY state machine + down-counter)
// Holds busy high for MULT_CYCLES or DIV_CYCLES cycles, starting on the edge after
// an accepted start. Only instantiated when PIPE_HAZARD_CTRL_MDU_EN is defined.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  synchronous, active-high
//   start  in  E-stage instruction starts a mult/div
//   is_div in  with start: 1 = div, 0 = mult
//   cancel in  exception flush; suppresses a start in the same cycle
//   busy   out timer running (state == BUSY)
module md_busy_timer
   import pipe_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   input  logic cancel,
   output logic busy
);

   ctrl_state_e         state_q, state_d;
   logic [MD_CNT_W-1:0] cnt_q, cnt_d;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RUN: begin
            // A start coinciding with a flush never reaches the MDU.
            if (start && !cancel) begin
               state_d = BUSY;
               cnt_d   = is_div ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
            end
         end
         BUSY: begin
            // Starts are ignored here; a flush does not abort the running op.
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= MD_CNT_W'(1)) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state_q == BUSY);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - five-stage pipeline stall/flush controller
// Decides each cycle whether F/D advance, E takes a bubble, or a flush wins.
// Optional macro PIPE_HAZARD_CTRL_MDU_EN adds the MDU busy timer and MD hazard;
// without it md_busy is 0 and D_md_op/E_md_start/E_md_div are ignored.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   D_rs, D_rt            D-stage source registers
//   D_tuse_rs, D_tuse_rt  cycles until each source is consumed (3 = unused)
//   E_wa, E_tnew          E-stage write address (0 = none) and result latency
//   M_wa, M_tnew          M-stage write address and result latency
//   D_md_op               D-stage instruction uses the MDU or HI/LO
//   E_md_start, E_md_div  E-stage mult/div start and its kind
//   int_req               exception/interrupt request
//   stall, FD_en, E_clr   combined stall and stage-register controls
//   flush_req             flush request to the D/E/M/W registers
//   md_busy               MDU timer running
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] D_rs,
   input  logic [4:0] D_rt,
   input  logic [1:0] D_tuse_rs,
   input  logic [1:0] D_tuse_rt,
   input  logic [4:0] E_wa,
   input  logic [1:0] E_tnew,
   input  logic [4:0] M_wa,
   input  logic [1:0] M_tnew,
   input  logic       D_md_op,
   input  logic       E_md_start,
   input  logic       E_md_div,
   input  logic       int_req,
   output logic       stall,
   output logic       FD_en,
   output logic       E_clr,
   output logic       flush_req,
   output logic       md_busy
);

   logic rs_hazard;
   logic rt_hazard;
   logic md_hazard;

   // A source with Tuse == TUSE_NONE is never read, so it cannot hazard.
   function automatic logic src_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                       input logic [4:0] e_wa, input logic [1:0] e_tnew,
                                       input logic [4:0] m_wa, input logic [1:0] m_tnew);
      logic hit_e;
      logic hit_m;
      hit_e = (src == e_wa) && (tuse < e_tnew);
      hit_m = (src == m_wa) && (tuse < m_tnew);
      return (src != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
   endfunction

   always_comb begin
      rs_hazard = src_hazard(D_rs, D_tuse_rs, E_wa, E_tnew, M_wa, M_tnew);
      rt_hazard = src_hazard(D_rt, D_tuse_rt, E_wa, E_tnew, M_wa, M_tnew);
   end

`ifdef PIPE_HAZARD_CTRL_MDU_EN
   md_busy_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy_timer (
      .clk    (clk),
      .reset  (reset),
      .start  (E_md_start),
      .is_div (E_md_div),
      .cancel (int_req),
      .busy   (md_busy)
   );

   // The start cycle itself must also hold a HI/LO consumer in D.
   assign md_hazard = D_md_op && (md_busy || E_md_start);
`else
   logic                unused_md_inputs;
   logic [MD_CNT_W-1:0] unused_md_params;

   assign unused_md_inputs = D_md_op ^ E_md_start ^ E_md_div ^ clk ^ reset;
   assign unused_md_params = MD_CNT_W'(MULT_CYCLES) ^ MD_CNT_W'(DIV_CYCLES);
   assign md_busy          = 1'b0;
   assign md_hazard        = 1'b0;
`endif

   // Flush has priority: a stalled instruction is being discarded anyway.
   always_comb begin
      stall     = (rs_hazard || rt_hazard || md_hazard) && !int_req;
      FD_en     = !stall;
      E_clr     = stall;
      flush_req = int_req;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage core. Each cycle it decides whether the F/D pipeline registers advance, whether the E register loads a bubble, and whether an exception flush takes priority. It also owns the multiply/divide busy timer that holds HI/LO-dependent instructions in D. Its outputs drive the `en`, `clr` and `req` inputs of the stage registers directly.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- D_rs  in  5  source register A of the D-stage instruction
- D_rt  in  5  source register B of the D-stage instruction
- D_tuse_rs  in  2  cycles until rs is consumed; 3 means unused
- D_tuse_rt  in  2  cycles until rt is consumed; 3 means unused
- E_wa  in  5  E-stage write address; 0 means no write
- E_tnew  in  2  cycles until the E-stage result is available
- M_wa  in  5  M-stage write address
- M_tnew  in  2  cycles until the M-stage result is available
- D_md_op  in  1  D-stage instruction uses the MDU or HI/LO
- E_md_start  in  1  E-stage instruction starts a mult or div
- E_md_div  in  1  with E_md_start: 1 = div, 0 = mult
- int_req  in  1  exception/interrupt request from CP0
- stall  out  1  combined stall
- FD_en  out  1  enable for the F pc register and the D register
- E_clr  out  1  bubble insert into the E register
- flush_req  out  1  drives `req` on the D/E/M/W registers
- md_busy  out  1  MDU timer running

## Operation
- Reset: the state machine is in RUN and the counter is 0. Outputs after reset: md_busy=0, stall=0, FD_en=1, E_clr=0, flush_req=0 (with int_req=0 and no hazard).
- Data hazard on rs: D_rs≠0 and either (D_rs==E_wa and D_tuse_rs<E_tnew) or (D_rs==M_wa and D_tuse_rs<M_tnew). The rt hazard is defined the same way.
- MD hazard: D_md_op and (md_busy or E_md_start).
- stall = (data hazard or MD hazard) and not int_req.
- FD_en = not stall. E_clr = stall. flush_req = int_req. All four outputs are combinational.
- State machine has two states, RUN and BUSY.
  - RUN → BUSY on E_md_start and not int_req. The counter loads DIV_CYCLES if E_md_div, otherwise MULT_CYCLES.
  - In BUSY the counter decrements each cycle. BUSY → RUN when the counter is 1 (it reaches 0 on that edge).
  - md_busy = (state == BUSY).
- E_md_start while in BUSY is ignored; stall prevents it in legal flows.
- int_req in the same cycle as E_md_start suppresses the start.
- int_req during BUSY does not cancel the timer; the HI/LO op completes.
- Counter width: 4 bits unsigned. DIV_CYCLES must be ≤ 15.

## Timing
- Stall decisions take 0 cycles; they are valid in the same cycle as their inputs.
- md_busy rises on the edge after the E_md_start cycle. It stays high for exactly MULT_CYCLES or DIV_CYCLES cycles.
- A D_md_op instruction stalls in the start cycle plus every busy cycle. It enters E on the edge after md_busy falls.
- reset asserted mid-BUSY: the next edge gives RUN, counter 0, md_busy=0.
- Simultaneous int_req and hazard: flush wins. stall=0, flush_req=1.

## Configuration
- PIPE_HAZARD_CTRL_MDU_EN defined: the MDU timer, the BUSY state and the MD hazard are present as described.
- Not defined: the timer logic is removed. md_busy is tied to 0. The MD hazard term is 0. D_md_op, E_md_start and E_md_div are ignored. Data hazard and flush behaviour are unchanged.

## Structure
- Shared package pipe_pkg holds:
  - ctrl state enum {RUN, BUSY}
  - TUSE_NONE = 2'd3
  - MULT_CYCLES and DIV_CYCLES defaults
  - the 4-bit counter width constant
- Sub-module md_busy_timer contains the counter and state machine. Its interface is start, is_div, cancel, busy. It is instantiated only under PIPE_HAZARD_CTRL_MDU_EN.

## Test plan
- Load-use hazard: D_rs=5, D_tuse_rs=0, E_wa=5, E_tnew=2 → stall=1, FD_en=0, E_clr=1. With D_rs=0 → stall=0.
- Hazard into M: M_wa=7, M_tnew=1, D_rt=7, D_tuse_rt=1 → stall=0. With D_tuse_rt=0 → stall=1.
- Mult timing: E_md_start=1, E_md_div=0 at cycle 0 → md_busy high for cycles 1–5. D_md_op held high stalls cycles 0–5 and releases at cycle 6.
- Div timing: E_md_start=1, E_md_div=1 → md_busy high for exactly 10 cycles.
- Flush priority: int_req=1 together with a data hazard and E_md_start → flush_req=1, stall=0, md_busy stays 0 on the next cycle.
- Reset at busy cycle 3 of a div → md_busy=0 on the next cycle. Only with the macro undefined: an E_md_start sequence → md_busy stays 0.
